config_controller: RTL and testbench

Sequencer for the time/date/timer configuration path. It consumes the debounced button and switch levels produced by the front-end debouncer and edits BCD values for the selected field. On `escrib` it streams the active bank to the RTC bus driver through a request/acknowledge write handshake. It sits between the debouncer and the RTC write interface, and its packed BCD outputs feed the display.

---
 rtl/config_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_config_controller.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_controller.sv
// rtl/config_controller.sv - time/date/timer configuration sequencer with RTC write handshake
module config_controller #(
   parameter logic [7:0] TIME_BASE  = 8'h21,
   parameter logic [7:0] TIMER_BASE = 8'h41
) (
   input  logic        clk,
   input  logic        btn_reset,
   input  logic        dism,
   input  logic        aument,
   input  logic        derec,
   input  logic        izqda,
   input  logic        escrib,
   input  logic        sw_conf,
   input  logic        sw_CT,
   input  logic        DOCE_24,
   input  logic        wr_ack,
   output logic        cfg_active,
   output logic        busy,
   output logic [2:0]  field_sel,
   output logic [47:0] time_bcd,
   output logic [23:0] timer_bcd,
   output logic        wr_req,
   output logic [7:0]  wr_addr,
   output logic [7:0]  wr_data
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EDIT   = 2'd1;
   localparam logic [1:0] S_WR_REQ = 2'd2;
   localparam logic [1:0] S_WR_GAP = 2'd3;

   logic [1:0] state;
   logic [4:0] btn;        // {escrib, derec, izqda, aument, dism}
   logic [4:0] prev;
   logic [4:0] ev;         // registered rising-edge events, same bit order as btn
   logic       prev_ct;
   logic       ct_changed;
   logic       in_write;
   logic       wr_bank;    // bank latched at the write command
   logic [2:0] wr_idx;
   logic [2:0] last_field;
   logic [7:0] secs, mins, hours, days, mons, years;
   logic [7:0] t_secs, t_mins, t_hours;
   logic [7:0] sel_val;
   logic [7:0] stepped;
   logic [7:0] hour_norm;
   logic       hour_bad;
   logic [6:0] lo, hi;

   function automatic logic [6:0] bcd2bin(input logic [7:0] b);
      return ({3'b000, b[7:4]} * 7'd10) + {3'b000, b[3:0]};
   endfunction

   function automatic logic [7:0] bin2bcd(input logic [6:0] v);
      logic [3:0] tens;
      tens = 4'(v / 7'd10);
      return {tens, 4'(v - {3'b000, tens} * 7'd10)};
   endfunction

   // One BCD step inside [lo_b, hi_b], wrapping at either end
   function automatic logic [7:0] bcd_step(input logic [7:0] val, input logic up,
                                           input logic [6:0] lo_b, input logic [6:0] hi_b);
      logic [6:0] v;
      v = bcd2bin(val);
      if (up)
         return bin2bcd((v >= hi_b) ? lo_b : v + 7'd1);
      else
         return bin2bcd((v <= lo_b) ? hi_b : v - 7'd1);
   endfunction

   assign btn        = {escrib, derec, izqda, aument, dism};
   assign in_write   = state[1];   // both write states have bit 1 set
   assign ct_changed = (sw_CT != prev_ct);
   assign last_field = sw_CT ? 3'd2 : 3'd5;

   // 12 h display keeps the hour in 01..12; 00 maps to 12, 13..23 drop by twelve
   assign hour_bad  = (hours == 8'h00) || (hours > 8'h12);
   assign hour_norm = (hours == 8'h00) ? 8'h12 : bin2bcd(bcd2bin(hours) - 7'd12);

   assign cfg_active = (state != S_IDLE);
   assign busy       = in_write;
   assign wr_req     = (state == S_WR_REQ);
   assign time_bcd   = {years, mons, days, hours, mins, secs};
   assign timer_bcd  = {t_hours, t_mins, t_secs};

   // Value and legal range of the field under the cursor, plus its stepped value
   always_comb begin
      sel_val = 8'h00;
      lo      = 7'd0;
      hi      = 7'd59;
      if (sw_CT) begin
         case (field_sel)
            3'd0: sel_val = t_secs;
            3'd1: sel_val = t_mins;
            3'd2: begin sel_val = t_hours; hi = 7'd23; end
            default: ;
         endcase
      end else begin
         case (field_sel)
            3'd0: sel_val = secs;
            3'd1: sel_val = mins;
            3'd2: begin
               sel_val = hours;
               lo      = DOCE_24 ? 7'd1 : 7'd0;
               hi      = DOCE_24 ? 7'd12 : 7'd23;
            end
            3'd3: begin sel_val = days;  lo = 7'd1; hi = 7'd31; end
            3'd4: begin sel_val = mons;  lo = 7'd1; hi = 7'd12; end
            3'd5: begin sel_val = years; hi = 7'd99; end
            default: ;
         endcase
      end
      stepped = bcd_step(sel_val, ev[1], lo, hi);
   end

   // Address and data of the field currently being written
   always_comb begin
      wr_addr = 8'h00;
      wr_data = 8'h00;
      if (wr_req) begin
         wr_addr = (wr_bank ? TIMER_BASE : TIME_BASE) + {5'b00000, wr_idx};
         case ({wr_bank, wr_idx})
            4'b0000: wr_data = secs;
            4'b0001: wr_data = mins;
            4'b0010: wr_data = hours;
            4'b0011: wr_data = days;
            4'b0100: wr_data = mons;
            4'b0101: wr_data = years;
            4'b1000: wr_data = t_secs;
            4'b1001: wr_data = t_mins;
            4'b1010: wr_data = t_hours;
            default: wr_data = 8'h00;
         endcase
      end
   end

   // Button edge detection; events are only captured while editing, so nothing queues up
   always_ff @(posedge clk) begin
      if (btn_reset) begin
         prev <= 5'b11111;
         ev   <= 5'b00000;
      end else begin
         prev <= btn;
         ev   <= (state == S_EDIT) ? (btn & ~prev) : 5'b00000;
      end
   end

   // Sequencer, cursor and field registers
   always_ff @(posedge clk) begin
      if (btn_reset) begin
         state     <= S_IDLE;
         field_sel <= 3'd0;
         wr_idx    <= 3'd0;
         wr_bank   <= 1'b0;
         prev_ct   <= sw_CT;
         secs      <= 8'h00;
         mins      <= 8'h00;
         hours     <= 8'h00;
         days      <= 8'h01;
         mons      <= 8'h01;
         years     <= 8'h00;
         t_secs    <= 8'h00;
         t_mins    <= 8'h00;
         t_hours   <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (sw_conf) state <= S_EDIT;
            end
            S_EDIT: begin
               if (!sw_conf) begin
                  state <= S_IDLE;
               end else if (!ct_changed) begin
                  if (ev[4]) begin
                     state   <= S_WR_REQ;
                     wr_idx  <= 3'd0;
                     wr_bank <= sw_CT;
                  end else if (ev[3]) begin
                     field_sel <= (field_sel >= last_field) ? 3'd0 : field_sel + 3'd1;
                  end else if (ev[2]) begin
                     field_sel <= (field_sel == 3'd0) ? last_field : field_sel - 3'd1;
                  end else if (ev[1] || ev[0]) begin
                     if (sw_CT) begin
                        case (field_sel)
                           3'd0: t_secs  <= stepped;
                           3'd1: t_mins  <= stepped;
                           3'd2: t_hours <= stepped;
                           default: ;
                        endcase
                     end else begin
                        case (field_sel)
                           3'd0: secs  <= stepped;
                           3'd1: mins  <= stepped;
                           3'd2: hours <= stepped;
                           3'd3: days  <= stepped;
                           3'd4: mons  <= stepped;
                           3'd5: years <= stepped;
                           default: ;
                        endcase
                     end
                  end
               end
            end
            S_WR_REQ: begin
               if (wr_ack) begin
                  if (wr_idx == (wr_bank ? 3'd2 : 3'd5))
                     state <= sw_conf ? S_EDIT : S_IDLE;
                  else
                     state <= S_WR_GAP;
               end
            end
            default: begin
               wr_idx <= wr_idx + 3'd1;
               state  <= S_WR_REQ;
            end
         endcase

         // Switch changes are frozen during a write and take effect once it ends
         if (!in_write) begin
            prev_ct <= sw_CT;
            if (ct_changed) field_sel <= 3'd0;
            if (DOCE_24 && hour_bad) hours <= hour_norm;
         end
      end
   end

endmodule

// File: tb/tb_config_controller.sv
// tb/tb_config_controller.sv - scoreboard bench for config_controller
module tb_config_controller;

   logic        clk = 1'b0;
   logic        btn_reset, sw_conf, sw_CT, DOCE_24, wr_ack;
   logic [4:0]  b;   // {escrib, derec, izqda, aument, dism}
   logic        cfg_active, busy, wr_req;
   logic [2:0]  field_sel;
   logic [47:0] time_bcd;
   logic [23:0] timer_bcd;
   logic [7:0]  wr_addr, wr_data;

   localparam logic [4:0] B_ESC = 5'b10000;
   localparam logic [4:0] B_DER = 5'b01000;
   localparam logic [4:0] B_IZQ = 5'b00100;
   localparam logic [4:0] B_AUM = 5'b00010;
   localparam logic [4:0] B_DIS = 5'b00001;

   localparam int S_CFG = 0, S_BUSY = 1, S_FS = 2, S_TIME = 3, S_TIMER = 4,
                  S_REQ = 5, S_ADDR = 6, S_DATA = 7;

   config_controller dut (
      .clk        (clk),
      .btn_reset  (btn_reset),
      .dism       (b[0]),
      .aument     (b[1]),
      .derec      (b[3]),
      .izqda      (b[2]),
      .escrib     (b[4]),
      .sw_conf    (sw_conf),
      .sw_CT      (sw_CT),
      .DOCE_24    (DOCE_24),
      .wr_ack     (wr_ack),
      .cfg_active (cfg_active),
      .busy       (busy),
      .field_sel  (field_sel),
      .time_bcd   (time_bcd),
      .timer_bcd  (timer_bcd),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data)
   );

   always #5 clk = ~clk;

   int          npass = 0;
   int          ntotal = 0;
   string       name_q[$];
   int          sel_q[$];
   logic [47:0] exp_q[$];
   logic [15:0] wr_exp_q[$];
   int          ack_delay = 0;
   int          ack_budget = 1000;
   int          ack_cnt = 0;
   logic        last_req = 1'b0;
   logic        gap_track = 1'b0;
   int          gap_cnt = 0;

   function automatic logic [47:0] sig(input int sel);
      case (sel)
         S_CFG:   return {47'b0, cfg_active};
         S_BUSY:  return {47'b0, busy};
         S_FS:    return {45'b0, field_sel};
         S_TIME:  return time_bcd;
         S_TIMER: return {24'b0, timer_bcd};
         S_REQ:   return {47'b0, wr_req};
         S_ADDR:  return {40'b0, wr_addr};
         default: return {40'b0, wr_data};
      endcase
   endfunction

   task automatic check(input string name, input int sel, input logic [47:0] expv);
      name_q.push_back(name);
      sel_q.push_back(sel);
      exp_q.push_back(expv);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [4:0] m);
      b = m;
      tick(1);
      b = 5'b00000;
      tick(2);
   endtask

   task automatic press_n(input logic [4:0] m, input int n);
      for (int i = 0; i < n; i++) press(m);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && busy; i++) tick(1);
      tick(2);
   endtask

   // Scoreboard monitor: drains probe expectations and checks every write request
   always @(negedge clk) begin
      string       nm;
      int          sl;
      logic [47:0] ex;
      logic [47:0] act;
      logic [15:0] w;
      while (exp_q.size() > 0) begin
         nm  = name_q.pop_front();
         sl  = sel_q.pop_front();
         ex  = exp_q.pop_front();
         act = sig(sl);
         ntotal++;
         if (act === ex) npass++;
         else $display("FAIL %s: got %0h, required %0h", nm, act, ex);
      end
      if (wr_req) begin
         if (!last_req) begin
            if (gap_track) begin
               ntotal++;
               if (gap_cnt == 1) npass++;
               else $display("FAIL wr_gap: wr_req low for %0d cycles, required 1", gap_cnt);
            end
            ntotal++;
            if (wr_exp_q.size() == 0) begin
               $display("FAIL wr_unexpected: addr/data %02h/%02h, no request required",
                        wr_addr, wr_data);
            end else begin
               w = wr_exp_q.pop_front();
               if ({wr_addr, wr_data} === w) npass++;
               else $display("FAIL wr_xfer: addr/data %02h/%02h, required %02h/%02h",
                             wr_addr, wr_data, w[15:8], w[7:0]);
            end
            gap_cnt   = 0;
            gap_track = 1'b1;
         end
      end else if (busy) begin
         gap_cnt++;
      end else begin
         gap_track = 1'b0;
         gap_cnt   = 0;
      end
      last_req = wr_req;
   end

   // RTC-side responder: acknowledges a request ack_delay cycles after it rises
   initial begin
      wr_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (wr_ack) begin
            wr_ack  = 1'b0;
            ack_cnt = 0;
         end else if (wr_req && ack_budget > 0) begin
            if (ack_cnt == ack_delay) begin
               wr_ack = 1'b1;
               ack_budget--;
            end else begin
               ack_cnt++;
            end
         end else begin
            ack_cnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w;
      btn_reset = 1'b1;
      sw_conf   = 1'b0;
      sw_CT     = 1'b0;
      DOCE_24   = 1'b0;
      b         = B_AUM;   // held through reset
      tick(3);
      check("rst_cfg_active", S_CFG, 0);
      check("rst_busy", S_BUSY, 0);
      check("rst_field_sel", S_FS, 0);
      check("rst_wr_req", S_REQ, 0);
      check("rst_wr_addr", S_ADDR, 0);
      check("rst_wr_data", S_DATA, 0);
      check("rst_time", S_TIME, 48'h00_01_01_00_00_00);
      check("rst_timer", S_TIMER, 0);

      btn_reset = 1'b0;
      sw_conf   = 1'b1;
      tick(3);
      b = 5'b00000;
      tick(2);
      check("held_btn_no_event", S_TIME, 48'h00_01_01_00_00_00);
      check("edit_active", S_CFG, 1);

      press_n(B_AUM, 59);
      check("sec_59", S_TIME, 48'h00_01_01_00_00_59);
      press(B_AUM);
      check("sec_wrap_00", S_TIME, 48'h00_01_01_00_00_00);
      press(B_AUM);
      check("sec_61_pulses", S_TIME, 48'h00_01_01_00_00_01);
      press_n(B_DIS, 2);
      check("sec_dec_wrap_59", S_TIME, 48'h00_01_01_00_00_59);

      btn_reset = 1'b1;
      DOCE_24   = 1'b1;
      tick(2);
      check("rst12_hold", S_TIME, 48'h00_01_01_00_00_00);
      btn_reset = 1'b0;
      tick(1);
      check("rst12_hour_12", S_TIME, 48'h00_01_01_12_00_00);
      press_n(B_DER, 2);
      check("cursor_hour", S_FS, 2);
      press(B_AUM);
      check("h12_inc_wrap_01", S_TIME, 48'h00_01_01_01_00_00);
      press_n(B_DIS, 2);
      check("h12_dec_11", S_TIME, 48'h00_01_01_11_00_00);
      DOCE_24 = 1'b0;
      press_n(B_DIS, 13);
      check("h24_dec_22", S_TIME, 48'h00_01_01_22_00_00);
      DOCE_24 = 1'b1;
      tick(1);
      check("h12_norm_10", S_TIME, 48'h00_01_01_10_00_00);
      DOCE_24 = 1'b0;
      tick(1);
      check("h24_keep_10", S_TIME, 48'h00_01_01_10_00_00);

      press_n(B_IZQ, 2);
      check("cursor_left_0", S_FS, 0);
      press(B_IZQ);
      check("cursor_wrap_5", S_FS, 5);
      press(B_DER);
      check("cursor_wrap_0", S_FS, 0);
      press(B_IZQ);
      sw_CT = 1'b1;
      tick(1);
      check("bank_change_fs0", S_FS, 0);
      press(B_IZQ);
      check("timer_cursor_wrap_2", S_FS, 2);

      press(B_AUM);
      press(B_IZQ);
      press_n(B_AUM, 30);
      press(B_IZQ);
      press_n(B_AUM, 15);
      check("timer_set", S_TIMER, 24'h01_30_15);
      check("time_untouched", S_TIME, 48'h00_01_01_10_00_00);

      ack_delay = 2;
      wr_exp_q.push_back(16'h4115);
      wr_exp_q.push_back(16'h4230);
      wr_exp_q.push_back(16'h4301);
      press(B_ESC);
      check("timer_wr_busy", S_BUSY, 1);
      press(B_AUM);
      wait_idle();
      check("timer_wr_done_busy", S_BUSY, 0);
      check("timer_wr_back_edit", S_CFG, 1);
      check("aument_during_write_ignored", S_TIMER, 24'h01_30_15);
      check("timer_wr_fs", S_FS, 0);

      press(B_DER | B_AUM);
      check("simul_cursor_moves", S_FS, 1);
      check("simul_value_kept", S_TIMER, 24'h01_30_15);

      sw_CT = 1'b0;
      tick(1);
      check("bank_back_fs0", S_FS, 0);
      press(B_DER);
      ack_delay = 0;
      wr_exp_q.push_back(16'h2100);
      wr_exp_q.push_back(16'h2200);
      wr_exp_q.push_back(16'h2310);
      wr_exp_q.push_back(16'h2401);
      wr_exp_q.push_back(16'h2501);
      wr_exp_q.push_back(16'h2600);
      press(B_ESC);
      sw_CT = 1'b1;
      wait_idle();
      check("time_wr_done_busy", S_BUSY, 0);
      check("ct_change_after_write", S_FS, 0);
      check("time_wr_values_kept", S_TIME, 48'h00_01_01_10_00_00);

      ack_budget = 1;
      wr_exp_q.push_back(16'h4115);
      wr_exp_q.push_back(16'h4230);
      press(B_ESC);
      for (int i = 0; i < 20 && wr_exp_q.size() > 0; i++) tick(1);
      tick(1);
      btn_reset = 1'b1;
      tick(1);
      check("abort_wr_req", S_REQ, 0);
      check("abort_busy", S_BUSY, 0);
      check("abort_idle", S_CFG, 0);
      check("abort_time", S_TIME, 48'h00_01_01_00_00_00);
      check("abort_timer", S_TIMER, 0);
      check("abort_fs", S_FS, 0);
      btn_reset = 1'b0;
      sw_conf   = 1'b0;
      tick(5);
      check("abort_no_more_req", S_REQ, 0);
      check("abort_stays_idle", S_CFG, 0);

      tick(2);
      while (wr_exp_q.size() > 0) begin
         w = wr_exp_q.pop_front();
         ntotal++;
         $display("FAIL wr_missing: no request seen, required addr/data %02h/%02h", w[15:8], w[7:0]);
      end
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
